// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller (load-use stall, branch flush, imem miss); HAZARD_STALL_CNT_EN adds stall_cnt
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_uses_rt,
  input  logic [4:0]  EX_rt,
  input  logic        EX_memread,
  input  logic        EX_branch_taken,
  input  logic        IF_imem_ready,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
`ifdef HAZARD_STALL_CNT_EN
  output logic [31:0] stall_cnt,
`endif
  output logic [1:0]  ctrl_state
);
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, IMISS = 2'd2} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic lu, run_or_miss;
  // priority-resolved outputs and next state
  always_comb begin
    lu = EX_memread && EX_rt != 5'd0 && (EX_rt == ID_rs || (ID_uses_rt && EX_rt == ID_rt));
    run_or_miss = state_q == RUN || state_q == IMISS;
    state_d = RUN;
    cnt_d = cnt_q;
    {pc_we, if_id_we, if_id_flush, id_ex_bubble} = 4'b1100;
    if (rst) begin
      {pc_we, if_id_we, if_id_flush, id_ex_bubble} = 4'b0111;
      cnt_d = 2'd0;
    end else if (EX_branch_taken) begin
      {pc_we, if_id_we, if_id_flush, id_ex_bubble} = 4'b1111;
      state_d = FLUSH_CYCLES > 1 ? FLUSH : RUN;
      cnt_d = 2'(FLUSH_CYCLES - 1);
    end else if (state_q == FLUSH) begin
      {pc_we, if_id_we, if_id_flush, id_ex_bubble} = {IF_imem_ready, 3'b110};
      cnt_d = cnt_q - 2'd1;
      state_d = cnt_q == 2'd1 ? RUN : FLUSH;
    end else if (lu && run_or_miss) begin
      {pc_we, if_id_we, if_id_flush, id_ex_bubble} = 4'b0001;
      state_d = state_q;
    end else if (!IF_imem_ready && run_or_miss) begin
      {pc_we, if_id_we, if_id_flush, id_ex_bubble} = 4'b0110;
      state_d = IMISS;
    end
  end
  // state and flush counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign ctrl_state = state_q;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  // count cycles where the PC is held
  always_comb stall_cnt_d = pc_we ? stall_cnt_q : stall_cnt_q + 32'd1;
  // stall counter register
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else stall_cnt_q <= stall_cnt_d;
  end
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized + directed scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
  localparam int F = 3;
  logic clk = 0, rst = 1;
  logic [4:0] ID_rs = 0, ID_rt = 0, EX_rt = 0;
  logic ID_uses_rt = 0, EX_memread = 0, EX_branch_taken = 0, IF_imem_ready = 1;
  logic pc_we, if_id_we, if_id_flush, id_ex_bubble;
  logic [1:0] ctrl_state;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  hazard_ctrl #(.FLUSH_CYCLES(F)) dut (
    .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
    .EX_rt(EX_rt), .EX_memread(EX_memread), .EX_branch_taken(EX_branch_taken),
    .IF_imem_ready(IF_imem_ready), .pc_we(pc_we), .if_id_we(if_id_we),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
`ifdef HAZARD_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .ctrl_state(ctrl_state));
  always #5 clk = ~clk;
  logic [5:0] expq[$];
  logic [31:0] cntq[$];
  int checks = 0, passed = 0;
  int flush_left = 0;
  bit miss = 0;
  logic [31:0] exp_cnt = 0;
  task automatic step(input logic r, b, rdy, mr, input logic [4:0] ert, irs, irt, input logic ut);
    logic [3:0] o;
    logic [1:0] st;
    bit lu_m;
    @(posedge clk);
    #2;
    rst = r; EX_branch_taken = b; IF_imem_ready = rdy; EX_memread = mr;
    EX_rt = ert; ID_rs = irs; ID_rt = irt; ID_uses_rt = ut;
    lu_m = mr && ert != 0 && (ert == irs || (ut && ert == irt));
    st = flush_left > 0 ? 2'd1 : miss ? 2'd2 : 2'd0;
    if (r) begin o = 4'b0111; flush_left = 0; miss = 0; end
    else if (b) begin o = 4'b1111; flush_left = F - 1; miss = 0; end
    else if (flush_left > 0) begin o = {rdy, 3'b110}; flush_left--; end
    else if (lu_m) o = 4'b0001;
    else if (!rdy) begin o = 4'b0110; miss = 1; end
    else begin o = 4'b1100; miss = 0; end
    expq.push_back({o, st});
    cntq.push_back(exp_cnt);
    if (r) exp_cnt = 0;
    else if (!o[3]) exp_cnt++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0, 0, 0, 0, 0);
  endtask
  // monitor: compare DUT outputs against queued expectations mid-cycle
  initial forever begin
    @(negedge clk);
    if (expq.size() > 0) begin
      logic [5:0] e, a;
      logic [31:0] ec;
      e = expq.pop_front();
      ec = cntq.pop_front();
      a = {pc_we, if_id_we, if_id_flush, id_ex_bubble, ctrl_state};
      checks++;
      if (a === e) passed++;
      else $display("FAIL outputs t=%0t {pc_we,if_id_we,flush,bubble,state} got=%b exp=%b", $time, a, e);
`ifdef HAZARD_STALL_CNT_EN
      checks++;
      if (stall_cnt === ec) passed++;
      else $display("FAIL stall_cnt t=%0t got=%h exp=%h", $time, stall_cnt, ec);
`else
      if (ec === 32'hx) $display("bad count model");
`endif
    end
  end
  initial begin
    @(posedge clk);
    #2;
    rst = 1;
    idle(2);
    step(0, 0, 1, 1, 5, 5, 0, 0);
    idle(2);
    step(0, 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 7, 1, 7, 1);
    step(0, 0, 1, 1, 7, 1, 7, 0);
    idle(1);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    idle(4);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3, 3, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    idle(3);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    idle(4);
`ifdef HAZARD_STALL_CNT_EN
    step(0, 0, 1, 1, 4, 4, 0, 0);
    #4;
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    exp_cnt = 0;
    idle(2);
`endif
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 80,
           $urandom_range(0, 99) < 35, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    @(negedge clk);
    #1;
    checks++;
    if (expq.size() == 0) passed++;
    else $display("FAIL drain pending=%0d exp=0", expq.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
